data_ram_resp: RTL and testbench
================================

// Module: data_ram_resp
// PURPOSE
//  Responder for the CPU data-memory port: serves ce/we/sel/addr/data from the core's MEM stage.
//  Word-organised RAM with byte-lane writes and programmable wait states.
//  Holds the pipeline through ctrl's stallreq input for the duration of each access.
//  Sits at top level beside the CPU, driving ram_data_i and a stall request for ctrl.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//  WAIT_CYCLES  2   extra wait cycles per access (0..15)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous, active-low reset
//  ce_i       in   1           access request (CPU ram_ce_o)
//  we_i       in   1           1 = write, 0 = read (CPU ram_we_o)
//  addr_i     in   32          byte address (CPU ram_addr_o)
//  sel_i      in   4           byte-lane enables (CPU ram_sel_o)
//  data_i     in   32          write data (CPU ram_data_o)
//  data_o     out  32          read data (to CPU ram_data_i)
//  stallreq_o out  1           stall request to ctrl; pipeline holds the MEM request while high
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, wait counter=0, data_o=0, stallreq_o=0.
//   - RAM contents not cleared; an in-flight access is dropped, no write occurs.
//  Addressing:
//   - word index = addr_i[ADDR_WIDTH+1:2]; addr_i[1:0] ignored (sel_i already encodes the lane).
//   - Upper address bits ignored; out-of-range addresses alias.
//   - Little-endian: sel_i[k] controls data_i[8k+7:8k] <-> byte (word*4+k).
//  FSM IDLE/WAIT/DONE:
//   - IDLE: if ce_i=1, capture we_i, addr_i, sel_i, data_i and load counter=WAIT_CYCLES.
//     Next state is WAIT if WAIT_CYCLES>0, else DONE.
//   - WAIT: counter decrements each cycle; at counter==1 go to DONE. ce_i=0 in WAIT -> abort to IDLE, no access.
//   - On the edge entering DONE:
//     write: RAM lanes with captured sel updated.
//     read: data_o <= RAM[word] (full word, all lanes).
//   - DONE lasts exactly 1 cycle, then IDLE. ce_i is not sampled in DONE.
//  stallreq_o (combinational): (IDLE & ce_i) | WAIT; 0 in DONE.
//   - Each access stalls for exactly WAIT_CYCLES+1 cycles.
//   - data_o is valid during DONE, when the MEM stage advances.
//  Back-to-back requests: the next request is seen in the cycle after DONE (IDLE) and is accepted there.
//  Request inputs changing during WAIT are ignored; the captured copy is used.
//  Writes leave data_o unchanged; data_o holds the last read value until the next read completes.
//  sel_i=4'b0000 write: full stall sequence, no byte modified.
//  Read of a never-written word returns X in simulation; the bench initialises RAM.
// TESTING
//  1 Reset: rst=0 mid-run -> data_o=0, stallreq_o=0 immediately; after release, IDLE with ce_i=0 -> stallreq_o=0.
//  2 WAIT_CYCLES=2, write 0xDEADBEEF @0x10 sel=1111:
//    stallreq_o high for 3 cycles; read @0x10 -> data_o=0xDEADBEEF in DONE, after 3 stall cycles.
//  3 Then write 0x0000AA00 @0x11 sel=0010 -> read @0x10 returns 0xDEADAAEF (addr[1:0] ignored).
//  4 WAIT_CYCLES=0, reads @0x0/@0x4 back-to-back (preloaded 0x11111111/0x22222222):
//    stall pattern 1,0,1,0; data 0x11111111, then 0x22222222.
//  5 Write 0xFFFFFFFF @0x20, ce_i dropped in 1st WAIT cycle -> FSM returns IDLE; later read @0x20 returns old value.
//  6 rst=0 during WAIT of a write @0x30 -> stallreq_o=0 at once, RAM @0x30 unchanged;
//    after rst=1, a new read completes normally.

Source files
------------

// File: rtl/data_ram_resp.sv
// data_ram_resp
//   Responder for the CPU data-memory port. A word-organised RAM with
//   byte-lane writes and WAIT_CYCLES programmable wait states. The MEM-stage
//   request is held by raising stallreq_o for exactly WAIT_CYCLES+1 cycles;
//   the access takes effect on the edge into DONE, and read data is
//   presented on data_o during DONE.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-low reset
//   ce_i        in   access request
//   we_i        in   1 = write, 0 = read
//   addr_i      in   byte address; word index = addr_i[ADDR_WIDTH+1:2]
//   sel_i       in   byte-lane enables, sel_i[k] <-> data_i[8k+7:8k]
//   data_i      in   write data
//   data_o      out  read data, holds the last read value
//   stallreq_o  out  stall request to the pipeline controller
module data_ram_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stallreq_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;

    logic                    req_we_p0;
    logic [ADDR_WIDTH-1:0]   req_word_p0;
    logic [3:0]              req_sel_p0;
    logic [31:0]             req_data_p0;

    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_word;
    logic [3:0]              acc_sel;
    logic [31:0]             acc_data;
    logic                    go_done;

    logic [31:0]             mem [DEPTH];

    // Upper address bits alias and the byte offset is carried by sel_i.
    logic                    unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ce_i) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!ce_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: stall is gated by rst so it drops the instant reset asserts.
    always_comb begin
        stallreq_o = rst & (((state_q == S_IDLE) & ce_i) | (state_q == S_WAIT));
    end

    // Stage p0: request captured on acceptance; later input changes are ignored
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && ce_i) begin
            req_we_p0   <= we_i;
            req_word_p0 <= addr_i[ADDR_WIDTH+1:2];
            req_sel_p0  <= sel_i;
            req_data_p0 <= data_i;
        end
    end

    // With zero wait states DONE is entered straight from IDLE, before the
    // captured copy exists, so the live request is used in that case.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we   = we_i;
            acc_word = addr_i[ADDR_WIDTH+1:2];
            acc_sel  = sel_i;
            acc_data = data_i;
        end else begin
            acc_we   = req_we_p0;
            acc_word = req_word_p0;
            acc_sel  = req_sel_p0;
            acc_data = req_data_p0;
        end
        go_done = rst && (state_q != S_DONE) && (state_d == S_DONE);
    end

    // Stage p1: RAM access on the edge into DONE
    always_ff @(posedge clk) begin
        if (go_done && acc_we) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_sel[k]) begin
                    mem[acc_word][8*k +: 8] <= acc_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o <= '0;
        end else if (go_done && !acc_we) begin
            data_o <= mem[acc_word];
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
module tb_data_ram_resp;

    logic        clk;
    logic        rst;
    logic        ce     [2];
    logic        we_s   [2];
    logic [31:0] addr   [2];
    logic [3:0]  sel    [2];
    logic [31:0] wdat   [2];
    logic [31:0] rdat   [2];
    logic        stall  [2];

    int errors = 0;
    int checks = 0;

    // Reference model: plain word arrays, one per instance, plus the value
    // data_o is expected to hold (last completed read, 0 after reset).
    logic [31:0] ref_mem [2][64];
    logic [31:0] last_rd [2];
    logic [31:0] exp_q   [$];
    int          scnt    [2];

    // Instance 0: two wait states. Instance 1: zero wait states.
    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we_s[0]), .addr_i(addr[0]),
        .sel_i(sel[0]), .data_i(wdat[0]), .data_o(rdat[0]), .stallreq_o(stall[0])
    );
    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we_s[1]), .addr_i(addr[1]),
        .sel_i(sel[1]), .data_i(wdat[1]), .data_o(rdat[1]), .stallreq_o(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an access completes when the request is up and no stall is
    // requested (DONE). Checks stall length and read data against the queue.
    initial begin
        scnt[0] = 0;
        scnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst && ce[k]) begin
                    if (stall[k]) begin
                        scnt[k]++;
                    end else begin
                        check("stall_cycles", 32'(scnt[k]), 32'(wait_of(k) + 1));
                        if (exp_q.size() == 0) begin
                            check("unexpected_completion", 32'd1, 32'd0);
                        end else begin
                            check("data_o", rdat[k], exp_q.pop_front());
                        end
                        scnt[k] = 0;
                    end
                end else begin
                    scnt[k] = 0;
                end
            end
        end
    end

    // Issue one access and push the model's expected data_o at DONE.
    // Leaves ce high through DONE so a following call is back-to-back.
    task automatic do_access(int k, bit we, logic [31:0] a, logic [3:0] s, logic [31:0] d);
        int w;
        bit done;
        @(posedge clk); #1;
        ce[k] = 1'b1; we_s[k] = we; addr[k] = a; sel[k] = s; wdat[k] = d;
        w = int'(a[7:2]);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[k][w][8*b +: 8] = d[8*b +: 8];
        end else begin
            last_rd[k] = ref_mem[k][w];
        end
        exp_q.push_back(last_rd[k]);
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!stall[k]) done = 1'b1;
        end
        if (!done) begin
            check("access_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic go_idle(int k);
        @(posedge clk); #1;
        ce[k] = 1'b0;
    endtask

    task automatic reset_all();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_data_o", rdat[k], 32'h0);
            check("rst_stall", 32'(stall[k]), 32'd0);
            last_rd[k] = 32'h0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ce[k] = 0; we_s[k] = 0; addr[k] = 0; sel[k] = 0; wdat[k] = 0;
        end
        reset_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_stall_w2", 32'(stall[0]), 32'd0);
        check("idle_stall_w0", 32'(stall[1]), 32'd0);

        // Initialise the low 64 words of both RAMs.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 64; w++)
                do_access(k, 1'b1, 32'(w * 4), 4'hF, $urandom);
            go_idle(k);
        end

        // Full write then read back, followed by a single-lane write at an
        // unaligned byte address.
        do_access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        go_idle(0);
        do_access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        go_idle(0);
        do_access(0, 1'b1, 32'h11, 4'b0010, 32'h0000AA00);
        go_idle(0);
        do_access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        go_idle(0);
        check("lane_merge_model", ref_mem[0][4], 32'hDEADAAEF);

        // Zero wait states: back-to-back reads.
        do_access(1, 1'b1, 32'h0, 4'hF, 32'h11111111);
        do_access(1, 1'b1, 32'h4, 4'hF, 32'h22222222);
        go_idle(1);
        do_access(1, 1'b0, 32'h0, 4'hF, 32'h0);
        do_access(1, 1'b0, 32'h4, 4'hF, 32'h0);
        go_idle(1);

        // ce dropped in the first WAIT cycle: no write may happen.
        @(posedge clk); #1;
        ce[0] = 1'b1; we_s[0] = 1'b1; addr[0] = 32'h20; sel[0] = 4'hF; wdat[0] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        ce[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_idle_stall", 32'(stall[0]), 32'd0);
        do_access(0, 1'b0, 32'h20, 4'hF, 32'h0);
        go_idle(0);

        // Reset during WAIT of a write.
        @(posedge clk); #1;
        ce[0] = 1'b1; we_s[0] = 1'b1; addr[0] = 32'h30; sel[0] = 4'hF; wdat[0] = 32'h0BADF00D;
        @(posedge clk); #1;
        reset_all();
        @(posedge clk); #1;
        ce[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_stall", 32'(stall[0]), 32'd0);
        do_access(0, 1'b0, 32'h30, 4'hF, 32'h0);
        go_idle(0);

        // Randomised traffic; sel_i=0 writes occur naturally.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                do_access(k, 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 2) == 0) go_idle(k);
            end
            go_idle(k);
        end
        do_access(0, 1'b1, 32'h3C, 4'b0000, 32'h12345678);
        go_idle(0);
        do_access(0, 1'b0, 32'h3C, 4'hF, 32'h0);
        go_idle(0);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
